// File: rtl/cache_controller.sv
// cache_controller: blocking CPU-side controller for a set-associative, write-through,
// no-write-allocate cache; drives an external tag/data array and a single memory port.
module cache_controller #(
    parameter int ADDR_SIZE  = 32,
    parameter int NUM_SETS   = 16,
    parameter int NUM_WAYS   = 4,
    parameter int BLOCK_SIZE = 32,
    localparam int WaySize = $clog2(NUM_WAYS),
    localparam int SetSize = $clog2(NUM_SETS),
    localparam int OffSize = $clog2(BLOCK_SIZE / 4),
    localparam int TagSize = ADDR_SIZE - SetSize - OffSize
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_SIZE-1:0]  req_addr,
    input  logic [BLOCK_SIZE-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [BLOCK_SIZE-1:0] resp_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_write,
    output logic [ADDR_SIZE-1:0]  mem_addr,
    output logic [BLOCK_SIZE-1:0] mem_wdata,
    input  logic                  mem_resp_valid,
    input  logic [BLOCK_SIZE-1:0] mem_rdata,
    output logic [WaySize-1:0]    way,
    output logic [SetSize-1:0]    set,
    output logic [TagSize-1:0]    tag,
    output logic                  write_enable,
    output logic [BLOCK_SIZE-1:0] write_data,
    input  logic [BLOCK_SIZE-1:0] read_data,
    input  logic [NUM_WAYS-1:0]   hits,
    input  logic [NUM_WAYS-1:0]   valid_flags
);
    typedef enum logic [1:0] {IDLE, LOOKUP, MEM_REQ, MEM_WAIT} state_t;

    state_t                state_q, state_d;
    logic [ADDR_SIZE-1:0]  addr_q, addr_d;
    logic                  write_q, write_d;
    logic [BLOCK_SIZE-1:0] wdata_q, wdata_d;
    logic [WaySize-1:0]    rr_q, rr_d;

    logic [WaySize-1:0] hit_way, free_way, victim;
    logic               hit, all_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rr_q    <= rr_d;
        end
    end

    // Descending scans so the lowest matching index wins.
    always_comb begin
        hit_way  = '0;
        free_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (hits[i])         hit_way  = WaySize'(i);
            if (!valid_flags[i]) free_way = WaySize'(i);
        end
        hit       = |hits;
        all_valid = &valid_flags;
        victim    = all_valid ? rr_q : free_way;
    end

    assign set       = addr_q[OffSize +: SetSize];
    assign tag       = addr_q[ADDR_SIZE-1 -: TagSize];
    assign mem_write = write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        write_d       = write_q;
        wdata_d       = wdata_q;
        rr_d          = rr_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        mem_req_valid = 1'b0;
        write_enable  = 1'b0;
        write_data    = wdata_q;
        way           = victim;
        case (state_q)
            IDLE: begin
                req_ready = rst;
                if (req_valid && req_ready) begin
                    addr_d  = req_addr;
                    write_d = req_write;
                    wdata_d = req_wdata;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                way = hit ? hit_way : victim;
                if (hit && !write_q) begin
                    resp_valid = 1'b1;
                    resp_rdata = read_data;
                    state_d    = IDLE;
                end else begin
                    write_enable = write_q && hit;
                    state_d      = MEM_REQ;
                end
            end
            MEM_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_resp_valid) begin
                    resp_valid = 1'b1;
                    state_d    = IDLE;
                    if (!write_q) begin
                        write_enable = 1'b1;
                        write_data   = mem_rdata;
                        resp_rdata   = mem_rdata;
                        if (all_valid)
                            rr_d = (rr_q == WaySize'(NUM_WAYS - 1)) ? '0 : rr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter ADDR_SIZE, default 32, byte-address width.
REQ-002 Parameter NUM_SETS, default 16, sets in attached cache array.
REQ-003 Parameter NUM_WAYS, default 4, ways in attached cache array.
REQ-004 Parameter BLOCK_SIZE, default 32, data width in bits of one cache line and of every data port.
REQ-005 Derived widths SHALL be: WaySize=$clog2(NUM_WAYS); SetSize=$clog2(NUM_SETS); OffSize=$clog2(BLOCK_SIZE/4); TagSize=ADDR_SIZE-SetSize-OffSize.
REQ-006 One clock; reset is asynchronous and active-low: ports clk and rst, with rst low forcing reset immediately, independent of clk.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  asynchronous active-low reset.
REQ-009 req_valid  in  1; req_ready  out  1; req_write  in  1; req_addr  in  ADDR_SIZE; req_wdata  in  BLOCK_SIZE: CPU request channel.
REQ-010 resp_valid  out  1; resp_rdata  out  BLOCK_SIZE: CPU response channel, no backpressure.
REQ-011 mem_req_valid  out  1; mem_req_ready  in  1; mem_write  out  1; mem_addr  out  ADDR_SIZE; mem_wdata  out  BLOCK_SIZE: memory request channel.
REQ-012 mem_resp_valid  in  1; mem_rdata  in  BLOCK_SIZE: memory response channel.
REQ-013 way  out  WaySize; set  out  SetSize; tag  out  TagSize; write_enable  out  1; write_data  out  BLOCK_SIZE: cache-array drive.
REQ-014 read_data  in  BLOCK_SIZE; hits  in  NUM_WAYS; valid_flags  in  NUM_WAYS: cache-array results, combinational on way/set/tag.

Function
REQ-015 FSM states SHALL be IDLE, LOOKUP, MEM_REQ, MEM_WAIT; reset state IDLE.
REQ-016 IDLE: req_ready=1; on req_valid&&req_ready, latch req_addr/req_write/req_wdata, go LOOKUP; req_ready=0 in all other states.
REQ-017 set/tag SHALL always come from the latched address: set=addr[OffSize+:SetSize], tag=addr[ADDR_SIZE-1-:TagSize].
REQ-018 LOOKUP: way=index of lowest set bit of hits; if hits==0, way=victim (REQ-022).
REQ-019 LOOKUP read hit: resp_valid=1 for exactly one cycle, resp_rdata=read_data, next IDLE (2 cycles from accept edge to response).
REQ-020 LOOKUP read miss, or any write: next MEM_REQ; write hit additionally asserts write_enable one cycle with write_data=latched wdata to hit way (write-through); write miss does not allocate.
REQ-021 MEM_REQ: mem_req_valid=1, mem_write=latched write, mem_addr=latched addr, mem_wdata=latched wdata, all stable until mem_req_ready sampled high, then MEM_WAIT.
REQ-022 Victim = lowest-index way with valid_flags bit 0; if all valid, global round-robin pointer rr (WaySize bits, reset 0); rr increments mod NUM_WAYS only on a fill that used it.
REQ-023 MEM_WAIT: on mem_resp_valid, read: write_enable=1, way=victim, write_data=mem_rdata, resp_valid=1, resp_rdata=mem_rdata; write: resp_valid=1, resp_rdata=0; next IDLE. mem_resp_valid outside MEM_WAIT SHALL be ignored.
REQ-024 write_enable SHALL never assert outside REQ-020/REQ-023 cases; at most one cache write per request.
REQ-025 Request accepted in the same cycle resp_valid pulses is impossible (req_ready low); back-to-back requests have one idle cycle minimum.

Reset
REQ-026 rst low: state=IDLE, rr=0, latched regs=0; req_ready=0 while rst low, =1 first cycle after release; resp_valid, mem_req_valid, write_enable=0.
REQ-027 Reset mid-MEM_REQ or MEM_WAIT SHALL abandon the transaction with no cache write and no response; later mem_resp_valid ignored.

Verification
REQ-028 Read miss addr 0x40 (set 8), mem_rdata 0xDEADBEEF -> mem_req at 0x40, fill way 0, resp 0xDEADBEEF; repeat read -> hit, resp 2 cycles after accept, no mem_req.
REQ-029 Fill set 0 in all 4 ways, then a 5th distinct-tag read miss -> victims 0,1,2,3 then way 0 (rr), rr=1 after.
REQ-030 Write hit 0x40 data 0x12345678 -> write_enable one cycle to hit way, mem write issued, following read returns 0x12345678 from cache.
REQ-031 Write miss 0x80 -> mem write only, write_enable never asserted, valid_flags unchanged.
REQ-032 mem_req_ready held low 5 cycles -> mem_req_valid/mem_addr stable for all 5; rst pulsed low in MEM_WAIT -> no resp_valid, no write_enable, req_ready=1 after release.
